// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction stream loader.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned MAX_WORDS   = 1023;
  localparam int unsigned ADDR_WIDTH  = 10;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2
  } loader_state_e;

endpackage

// File: rtl/instruction_ram.sv
// Instruction memory: one synchronous write port, one synchronous read port.
// Ports:
//   clk      : clock, rising edge
//   we       : write enable, writes wr_data to mem[wr_addr]
//   wr_addr  : write word address
//   wr_data  : write word
//   re       : read enable; when low the read register loads IDLE_VALUE
//   rd_addr  : read word address
//   rd_data  : registered read word, valid one cycle after re
module instruction_ram #(
  parameter int unsigned DEPTH      = cpu_pkg::MAX_WORDS,
  parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE = cpu_pkg::NOP_INSTRUCTION
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the idle-value output register
  always_ff @(posedge clk) begin
    if (re) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= IDLE_VALUE;
    end
  end

endmodule

// File: rtl/instruction_stream_loader.sv
// Loads a program from a host byte stream into instruction memory and replays
// it to the cpu one word per clock.
// Ports:
//   clock_in            : system clock, rising edge
//   reset_n             : synchronous active-low reset
//   byte_valid/byte_data: host byte stream, LSB of each word first
//   byte_ready          : high in LOAD, byte accepted on valid&&ready
//   load_done           : pulse, ends the load and latches program_length
//   load_req            : pulse, discards the program and re-enters LOAD
//   start               : pulse, replays the stored program
//   current_instruction : word presented to the cpu (NOP when idle)
//   instruction_valid   : current_instruction is a real program word
//   program_length      : number of complete words stored
//   busy                : high while replaying
//   overflow            : sticky, a word arrived with memory full
module instruction_stream_loader #(
  parameter int unsigned MAX_WORDS  = cpu_pkg::MAX_WORDS,
  parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter logic [cpu_pkg::INSTR_WIDTH-1:0] NOP_INSTRUCTION = cpu_pkg::NOP_INSTRUCTION
) (
  input  logic                            clock_in,
  input  logic                            reset_n,
  input  logic                            byte_valid,
  input  logic [7:0]                      byte_data,
  output logic                            byte_ready,
  input  logic                            load_done,
  input  logic                            load_req,
  input  logic                            start,
  output logic [cpu_pkg::INSTR_WIDTH-1:0] current_instruction,
  output logic                            instruction_valid,
  output logic [ADDR_WIDTH-1:0]           program_length,
  output logic                            busy,
  output logic                            overflow
);

  import cpu_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] FULL_ADDR = ADDR_WIDTH'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  loader_state_e state_q, state_d;

  logic [1:0]            byte_count_q, byte_count_d;
  logic [23:0]           asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] program_length_q, program_length_d;
  logic                  overflow_q, overflow_d;
  logic                  byte_ready_q, busy_q, instruction_valid_q;

  logic                  byte_accept_c, word_done_c, ram_we_c, ram_re_c;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_c;
  logic [INSTR_WIDTH-1:0] ram_rd_data;

  // State register
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load_req has priority over start in READY
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (load_done) state_d = READY;
      end
      READY: begin
        if (load_req) begin
          state_d = LOAD;
        end else if (start && (program_length_q != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // rd_addr reaching the length means the last word is on the output now
        if (rd_addr_q == program_length_q) state_d = READY;
      end
      default: state_d = LOAD;
    endcase
  end

  // Datapath / output next-value logic
  always_comb begin
    byte_count_d     = byte_count_q;
    asm_d            = asm_q;
    wr_addr_d        = wr_addr_q;
    rd_addr_d        = rd_addr_q;
    program_length_d = program_length_q;
    overflow_d       = overflow_q;
    ram_re_c         = 1'b0;
    ram_rd_addr_c    = rd_addr_q;
    byte_accept_c    = byte_valid && byte_ready_q;
    word_done_c      = byte_accept_c && (byte_count_q == 2'd3);
    ram_we_c         = word_done_c && (wr_addr_q != FULL_ADDR);

    case (state_q)
      LOAD: begin
        if (byte_accept_c) begin
          byte_count_d = byte_count_q + 2'd1;
          // Lane 3 bypasses the assembly register straight into the write
          case (byte_count_q)
            2'd0:    asm_d[7:0]   = byte_data;
            2'd1:    asm_d[15:8]  = byte_data;
            2'd2:    asm_d[23:16] = byte_data;
            default: asm_d        = asm_q;
          endcase
        end
        if (ram_we_c) begin
          wr_addr_d = wr_addr_q + ADDR_ONE;
        end
        if (word_done_c && (wr_addr_q == FULL_ADDR)) begin
          overflow_d = 1'b1;
        end
        // Uses wr_addr_d so a word completing in the same cycle is counted
        if (load_done) begin
          program_length_d = wr_addr_d;
          byte_count_d     = 2'd0;
        end
      end
      READY: begin
        if (load_req) begin
          wr_addr_d        = '0;
          byte_count_d     = 2'd0;
          program_length_d = '0;
          overflow_d       = 1'b0;
        end else if (start && (program_length_q != '0)) begin
          // Issue word 0 now so it appears in the first RUN cycle
          ram_re_c      = 1'b1;
          ram_rd_addr_c = '0;
          rd_addr_d     = ADDR_ONE;
        end
      end
      RUN: begin
        if (rd_addr_q != program_length_q) begin
          ram_re_c  = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_ONE;
        end
      end
      default: begin
        ram_re_c = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      byte_count_q        <= 2'd0;
      asm_q               <= '0;
      wr_addr_q           <= '0;
      rd_addr_q           <= '0;
      program_length_q    <= '0;
      overflow_q          <= 1'b0;
      byte_ready_q        <= 1'b1;
      busy_q              <= 1'b0;
      instruction_valid_q <= 1'b0;
    end else begin
      byte_count_q        <= byte_count_d;
      asm_q               <= asm_d;
      wr_addr_q           <= wr_addr_d;
      rd_addr_q           <= rd_addr_d;
      program_length_q    <= program_length_d;
      overflow_q          <= overflow_d;
      byte_ready_q        <= (state_d == LOAD);
      busy_q              <= (state_d == RUN);
      instruction_valid_q <= ram_re_c;
    end
  end

  // Enables are gated by reset so a reset cycle neither writes nor presents a word
  instruction_ram #(
    .DEPTH      (MAX_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (INSTR_WIDTH),
    .IDLE_VALUE (NOP_INSTRUCTION)
  ) u_ram (
    .clk     (clock_in),
    .we      (ram_we_c && reset_n),
    .wr_addr (wr_addr_q),
    .wr_data ({byte_data, asm_q}),
    .re      (ram_re_c && reset_n),
    .rd_addr (ram_rd_addr_c),
    .rd_data (ram_rd_data)
  );

  assign byte_ready          = byte_ready_q;
  assign current_instruction = ram_rd_data;
  assign instruction_valid   = instruction_valid_q;
  assign program_length      = program_length_q;
  assign busy                = busy_q;
  assign overflow            = overflow_q;

endmodule

// File: tb/tb_instruction_stream_loader.sv
`timescale 1ns/1ps
// Directed bench for instruction_stream_loader with a replay scoreboard.
module tb_instruction_stream_loader;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        load_done = 1'b0;
  logic        load_req = 1'b0;
  logic        start = 1'b0;
  logic [31:0] current_instruction;
  logic        instruction_valid;
  logic [9:0]  program_length;
  logic        busy;
  logic        overflow;

  instruction_stream_loader dut (
    .clock_in            (clock_in),
    .reset_n             (reset_n),
    .byte_valid          (byte_valid),
    .byte_data           (byte_data),
    .byte_ready          (byte_ready),
    .load_done           (load_done),
    .load_req            (load_req),
    .start               (start),
    .current_instruction (current_instruction),
    .instruction_valid   (instruction_valid),
    .program_length      (program_length),
    .busy                (busy),
    .overflow            (overflow)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int unsigned cyc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [1024];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;

  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every presented word must match the scoreboard head, in its cycle
  always @(negedge clock_in) begin
    if (mon_en) begin
      if (instruction_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word actual=%h required=none (cycle %0d)", current_instruction, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("replay_word", current_instruction, e.word);
          check("replay_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("idle_nop", current_instruction, NOP);
      end
    end
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (byte_ready !== 1'b1 && t < 16) begin
      tick();
      t++;
    end
    if (t == 16) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  task automatic load_words(input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      model[i] = seed + 32'(i) * 32'h0103_0507;
      send_word(model[i]);
    end
  endtask

  task automatic pulse_load_done();
    load_done = 1'b1; tick(); load_done = 1'b0;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1; tick(); load_req = 1'b0;
  endtask

  // Start a replay of model[0..len-1]; optionally pulse start again mid-run
  task automatic run_prog(input int len, input bit poke);
    int unsigned n;
    int busy_cnt = 0;
    n = cyc;
    for (int k = 0; k < len; k++) sb_q.push_back('{n + 1 + k, model[k]});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < len + 4; i++) begin
      if (busy === 1'b1) busy_cnt++;
      start = poke && (i == 0 || i == 2);
      tick();
    end
    start = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'(len));
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("busy_after_run", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    mon_en = 1'b1;
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd1);
    check("rst_valid", {31'd0, instruction_valid}, 32'd0);
    check("rst_instr", current_instruction, NOP);
    check("rst_length", 32'(program_length), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // 1: two-word program
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    pulse_load_done();
    check("t1_length", 32'(program_length), 32'd2);
    check("t1_ready_low", {31'd0, byte_ready}, 32'd0);
    model[0] = 32'h1234_5678;
    model[1] = 32'hDEAD_BEEF;
    run_prog(2, 1'b0);

    // 2: trailing partial word discarded
    pulse_load_req();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    pulse_load_done();
    check("t2_length", 32'(program_length), 32'd1);
    model[0] = 32'h0403_0201;
    run_prog(1, 1'b0);

    // 3: overflow at full memory
    pulse_load_req();
    load_words(1023, 32'hC0DE_0000);
    check("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
    send_word(32'hBAD0_BAD0);
    check("t3_overflow", {31'd0, overflow}, 32'd1);
    pulse_load_done();
    check("t3_length", 32'(program_length), 32'd1023);
    check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
    run_prog(1023, 1'b0);

    // 4a: start with empty program is ignored
    pulse_load_req();
    check("t4_clr_length", 32'(program_length), 32'd0);
    check("t4_clr_overflow", {31'd0, overflow}, 32'd0);
    check("t4_load_ready", {31'd0, byte_ready}, 32'd1);
    pulse_load_done();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t4_empty_busy", {31'd0, busy}, 32'd0);
      check("t4_empty_ready", {31'd0, byte_ready}, 32'd0);
      tick();
    end
    // 4b: load_req beats start
    pulse_load_req();
    load_words(2, 32'h1111_0000);
    pulse_load_done();
    check("t4b_length", 32'(program_length), 32'd2);
    start = 1'b1; load_req = 1'b1; tick(); start = 1'b0; load_req = 1'b0;
    check("t4b_in_load", {31'd0, byte_ready}, 32'd1);
    check("t4b_length_clr", 32'(program_length), 32'd0);
    tick();
    check("t4b_busy", {31'd0, busy}, 32'd0);

    // 5: reset while word 3 of 10 is on the output
    load_words(10, 32'h5000_0000);
    pulse_load_done();
    check("t5_length", 32'(program_length), 32'd10);
    begin
      int unsigned n;
      n = cyc;
      for (int k = 0; k < 4; k++) sb_q.push_back('{n + 1 + k, model[k]});
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      check("t5_at_word3", current_instruction, model[3]);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("t5_valid", {31'd0, instruction_valid}, 32'd0);
      check("t5_instr", current_instruction, NOP);
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_byte_ready", {31'd0, byte_ready}, 32'd1);
      check("t5_length", 32'(program_length), 32'd0);
      tick();
      check("t5_sb_drained", 32'(sb_q.size()), 32'd0);
    end

    // 6: byte_valid held and extra starts during RUN are ignored
    load_words(3, 32'h6600_0000);
    pulse_load_done();
    byte_valid = 1'b1;
    byte_data  = 8'hFF;
    tick(); tick(); tick();
    check("t6_ready_low", {31'd0, byte_ready}, 32'd0);
    run_prog(3, 1'b1);
    check("t6_length", 32'(program_length), 32'd3);
    run_prog(3, 1'b0);
    byte_valid = 1'b0;
    tick();
    check("t6_length_kept", 32'(program_length), 32'd3);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
